// File: rtl/prog_mem_pkg.sv
// Shared types and elaboration helpers for the instruction memory and its loader.
package prog_mem_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  function automatic int unsigned beats_per_word(int unsigned w, int unsigned b);
    return w / b;
  endfunction

  // A word must be built from a whole number of beats.
  function automatic bit width_ok(int unsigned w, int unsigned b);
    return (b != 0) && ((w % b) == 0);
  endfunction

endpackage

// File: rtl/prog_mem_if.sv
// Program-load stream and instruction-fetch signals between the harness/fetch stage and prog_mem.
interface prog_mem_if #(
  parameter int unsigned A = 6,
  parameter int unsigned W = 8,
  parameter int unsigned B = 4
);
  logic         load_start;
  logic         load_valid;
  logic [B-1:0] load_data;
  logic         load_last;
  logic         load_ready;
  logic         fetch_en;
  logic [A-1:0] inst_address;
  logic [W-1:0] instr_out;
  logic         instr_valid;
  logic         busy;
  logic         load_done;
  logic         load_err;
  logic [A:0]   word_count;

  modport master (
    output load_start, load_valid, load_data, load_last, fetch_en, inst_address,
    input  load_ready, instr_out, instr_valid, busy, load_done, load_err, word_count
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last, fetch_en, inst_address,
    output load_ready, instr_out, instr_valid, busy, load_done, load_err, word_count
  );
endinterface

// File: rtl/prog_mem_array.sv
// DEPTH x W storage: one synchronous write port, one registered read port.
module prog_mem_array #(
  parameter int unsigned A = 6,
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [A-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic         re,
  input  logic [A-1:0] raddr,
  output logic [W-1:0] rdata
);
  localparam int unsigned Depth = 2 ** A;

  logic [W-1:0] mem [Depth];

  // Storage is deliberately not reset so a reset mid-load keeps earlier words.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/prog_mem.sv
// Instruction memory with a streamed program loader: packs B-bit beats into W-bit words
// written from address 0, then serves registered fetches once the program is loaded.
module prog_mem
  import prog_mem_pkg::*;
#(
  parameter int unsigned A = 6,
  parameter int unsigned W = 8,
  parameter int unsigned B = 4
) (
  input logic       clk,
  input logic       rst,
  prog_mem_if.slave bus
);
  localparam int unsigned Beats = beats_per_word(W, B);
  localparam int unsigned Depth = 2 ** A;
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;

  if (!width_ok(W, B)) begin : g_width_check
    $error("prog_mem: W must be an integer multiple of B");
  end

  state_e           state_q, state_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [W-1:0]     asm_q, asm_d, wr_word;
  logic [A:0]       count_q, count_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             valid_q;
  logic             accept, last_beat, word_end, full, we, re;

  assign bus.load_ready = (state_q == StLoad);
  assign accept         = bus.load_valid & bus.load_ready;
  assign last_beat      = (beat_q == BeatW'(Beats - 1));
  assign word_end       = accept & (last_beat | bus.load_last);
  assign full           = (count_q == (A + 1)'(Depth));
  assign we             = word_end & ~full;
  // A load request in RUN takes priority over a same-cycle fetch.
  assign re             = (state_q == StRun) & bus.fetch_en & ~bus.load_start;

  // Unfilled upper beats stay zero because asm_q is cleared after every written word.
  always_comb begin
    wr_word = asm_q;
    for (int k = 0; k < Beats; k++) begin
      if (beat_q == BeatW'(k)) begin
        wr_word[k*B +: B] = bus.load_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    asm_d   = asm_q;
    count_d = count_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle, StRun: begin
        if (bus.load_start) begin
          state_d = StLoad;
          beat_d  = '0;
          asm_d   = '0;
          count_d = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      StLoad: begin
        if (word_end) begin
          beat_d = '0;
          asm_d  = '0;
        end else if (accept) begin
          beat_d = beat_q + 1'b1;
          asm_d  = wr_word;
        end
        if (we) begin
          count_d = count_q + 1'b1;
        end
        if (word_end & full) begin
          err_d = 1'b1;
        end
        if (accept & bus.load_last) begin
          state_d = StRun;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      beat_q  <= '0;
      asm_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      asm_q   <= asm_d;
      count_q <= count_d;
      done_q  <= done_d;
      err_q   <= err_d;
      valid_q <= re;
    end
  end

  prog_mem_array #(
    .A(A),
    .W(W)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .waddr(count_q[A-1:0]),
    .wdata(wr_word),
    .re   (re),
    .raddr(bus.inst_address),
    .rdata(bus.instr_out)
  );

  assign bus.instr_valid = valid_q;
  assign bus.busy        = (state_q == StLoad);
  assign bus.load_done   = done_q;
  assign bus.load_err    = err_q;
  assign bus.word_count  = count_q;

endmodule

// File: tb/tb_prog_mem.sv
// Bench for prog_mem: directed and randomized program loads checked against a word-level model.
module tb_prog_mem;
  localparam int unsigned A     = 6;
  localparam int unsigned W     = 8;
  localparam int unsigned B     = 4;
  localparam int unsigned Beats = W / B;
  localparam int unsigned Depth = 1 << A;

  typedef logic [B-1:0] beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prog_mem_if #(.A(A), .W(W), .B(B)) bus ();

  prog_mem #(.A(A), .W(W), .B(B)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: memory contents as words, plus the load status.
  logic [W-1:0] ref_mem [Depth];
  bit           known   [Depth];
  int           ref_wc;
  bit           ref_done;
  bit           ref_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input bit exp_busy);
    check_eq({tag, "_wc"},   32'(bus.word_count), 32'(ref_wc));
    check_eq({tag, "_done"}, 32'(bus.load_done),  32'(ref_done));
    check_eq({tag, "_err"},  32'(bus.load_err),   32'(ref_err));
    check_eq({tag, "_busy"}, 32'(bus.busy),       32'(exp_busy));
  endtask

  task automatic start_load(input bit with_fetch);
    bus.load_start   = 1'b1;
    bus.fetch_en     = with_fetch;
    bus.inst_address = A'($urandom_range(0, Depth - 1));
    tick();
    bus.load_start = 1'b0;
    bus.fetch_en   = 1'b0;
    ref_wc   = 0;
    ref_done = 1'b0;
    ref_err  = 1'b0;
    check_eq("start_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("start_ready", 32'(bus.load_ready),  32'd1);
    check_status("start", 1'b1);
  endtask

  task automatic stream(input beat_t beats[$], input bit toggle, input bit with_last);
    int i   = 0;
    int cyc = 0;
    int n   = beats.size();
    int nfull, nw;
    bit acc;
    logic [W-1:0] word;
    while (i < n) begin
      if (toggle && (cyc % 2 == 1)) begin
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
      end else begin
        bus.load_valid = 1'b1;
        bus.load_data  = beats[i];
        bus.load_last  = with_last && (i == n - 1);
      end
      bus.fetch_en     = 1'($urandom_range(0, 1));
      bus.inst_address = A'($urandom_range(0, Depth - 1));
      acc = bus.load_valid && bus.load_ready;
      tick();
      if (acc) i++;
      cyc++;
      check_eq("load_no_fetch", 32'(bus.instr_valid), 32'd0);
      if (cyc > 4 * n + 10) begin
        check_eq("load_timeout", 32'(i), 32'(n));
        break;
      end
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    bus.fetch_en   = 1'b0;
    // Model: group beats into words, little-end beat first, zero-fill a partial last word.
    nfull = n / Beats;
    nw    = with_last ? (n + Beats - 1) / Beats : nfull;
    for (int w = 0; w < nw; w++) begin
      word = '0;
      for (int k = 0; k < Beats; k++) begin
        if (w * Beats + k < n) word = word | (W'(beats[w*Beats+k]) << (k * B));
      end
      if (w < Depth) begin
        ref_mem[w] = word;
        known[w]   = 1'b1;
      end
    end
    ref_wc = (nw > Depth) ? Depth : nw;
    if (with_last) begin
      ref_done = 1'b1;
      ref_err  = (nw > Depth);
    end
  endtask

  task automatic do_fetch(input int addr);
    logic [W-1:0] held;
    bus.fetch_en     = 1'b1;
    bus.inst_address = A'(addr);
    tick();
    bus.fetch_en = 1'b0;
    check_eq("fetch_valid", 32'(bus.instr_valid), 32'd1);
    check_eq("fetch_data",  32'(bus.instr_out),   32'(ref_mem[addr]));
    held = bus.instr_out;
    tick();
    check_eq("fetch_drop",  32'(bus.instr_valid), 32'd0);
    check_eq("fetch_hold",  32'(bus.instr_out),   32'(held));
  endtask

  beat_t q[$];

  initial begin
    bus.load_start   = 1'b0;
    bus.load_valid   = 1'b0;
    bus.load_data    = '0;
    bus.load_last    = 1'b0;
    bus.fetch_en     = 1'b0;
    bus.inst_address = '0;
    for (int i = 0; i < Depth; i++) known[i] = 1'b0;
    ref_wc   = 0;
    ref_done = 1'b0;
    ref_err  = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Fetch before any load is ignored.
    bus.fetch_en     = 1'b1;
    bus.inst_address = A'(5);
    tick();
    bus.fetch_en = 1'b0;
    check_eq("rst_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("rst_instr", 32'(bus.instr_out),   32'd0);
    check_eq("rst_ready", 32'(bus.load_ready),  32'd0);
    check_status("rst", 1'b0);

    // Two full words.
    q = '{4'hA, 4'h5, 4'h3, 4'hC};
    start_load(1'b0);
    stream(q, 1'b0, 1'b1);
    check_status("basic", 1'b0);
    check_eq("basic_wc2", 32'(bus.word_count), 32'd2);
    do_fetch(1);
    check_eq("basic_c3", 32'(bus.instr_out), 32'hC3);
    do_fetch(0);
    check_eq("basic_5a", 32'(bus.instr_out), 32'h5A);

    // Partial last word is zero-filled.
    q = '{4'h1, 4'h2, 4'h7};
    start_load(1'b0);
    stream(q, 1'b0, 1'b1);
    check_status("odd", 1'b0);
    do_fetch(1);
    check_eq("odd_07", 32'(bus.instr_out), 32'h07);
    do_fetch(0);
    check_eq("odd_21", 32'(bus.instr_out), 32'h21);

    // Overflow: 65 words into a 64-word memory.
    q.delete();
    for (int i = 0; i < 130; i++) q.push_back(beat_t'($urandom));
    start_load(1'b0);
    stream(q, 1'b0, 1'b1);
    check_status("ovf", 1'b0);
    check_eq("ovf_wc64", 32'(bus.word_count), 32'd64);
    check_eq("ovf_err",  32'(bus.load_err),   32'd1);
    do_fetch(0);
    do_fetch(63);

    // Back-pressure with valid toggling every cycle.
    q.delete();
    for (int i = 0; i < 11; i++) q.push_back(beat_t'($urandom));
    start_load(1'b0);
    stream(q, 1'b1, 1'b1);
    check_status("toggle", 1'b0);
    for (int a = 0; a < 6; a++) do_fetch(a);

    // Restart from RUN with a simultaneous fetch.
    q.delete();
    for (int i = 0; i < 5; i++) q.push_back(beat_t'($urandom));
    start_load(1'b1);
    stream(q, 1'b0, 1'b1);
    check_status("restart", 1'b0);
    for (int a = 0; a < 3; a++) do_fetch(a);

    // Reset after three beats of a reload: word 0 written, later words kept.
    q = '{4'h4, 4'hE, 4'h9};
    start_load(1'b0);
    stream(q, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ref_wc   = 0;
    ref_done = 1'b0;
    ref_err  = 1'b0;
    check_status("midrst", 1'b0);
    check_eq("midrst_ready", 32'(bus.load_ready), 32'd0);
    q = '{4'h6};
    start_load(1'b0);
    stream(q, 1'b0, 1'b1);
    check_status("after_rst", 1'b0);
    do_fetch(0);
    do_fetch(1);
    do_fetch(2);

    // Randomized programs.
    for (int it = 0; it < 8; it++) begin
      q.delete();
      for (int i = $urandom_range(1, 40); i > 0; i--) q.push_back(beat_t'($urandom));
      start_load(1'($urandom_range(0, 1)));
      stream(q, 1'($urandom_range(0, 1)), 1'b1);
      check_status("rand", 1'b0);
      for (int j = 0; j < 6; j++) do_fetch($urandom_range(0, ref_wc - 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_mem.md
# prog_mem

Parametrised instruction memory with a built-in synchronous program loader. It replaces the combinational, write-anywhere instruction store. A streamed program is accepted as B-bit beats over a valid/ready handshake and packed into W-bit words. Words are written sequentially from address 0. The block then serves registered instruction fetches to the fetch stage. It sits between the test-harness/boot loader and the PC/fetch logic.

## Interface
- A, 6, address width; DEPTH = 2**A words
- W, 8, instruction word width
- B, 4, load beat width; W must be an integer multiple of B; BEATS = W/B
- Clk  in  1  single clock, rising edge
- Reset  in  1  synchronous, active-high
- LoadStart  in  1  one-cycle pulse requesting a (re)load
- LoadValid  in  1  LoadData/LoadLast valid
- LoadData  in  B  program beat; first beat of a word is bits [B-1:0]
- LoadLast  in  1  marks final beat of the program
- LoadReady  out  1  block accepts a beat this cycle
- FetchEn  in  1  fetch request
- InstAddress  in  A  fetch address
- InstrOut  out  W  fetched instruction (registered)
- InstrValid  out  1  InstrOut holds data for the previous cycle's fetch
- Busy  out  1  state is LOAD
- LoadDone  out  1  program fully loaded; fetch permitted
- LoadErr  out  1  program exceeded DEPTH words
- WordCount  out  A+1  words written in the current/last load

## Operation
- States are IDLE, LOAD and RUN.
- Reset enters IDLE.
- IDLE to LOAD on LoadStart.
- RUN to LOAD on LoadStart. This clears WordCount, LoadDone and LoadErr and the beat index.
- LOAD to RUN when the beat carrying LoadLast is accepted.
- LoadStart in LOAD is ignored.
- Beat acceptance: LoadValid & LoadReady. LoadReady = (state == LOAD), combinational from state only.
- Packing: a beat counter runs 0..BEATS-1. Beat k fills bits [k*B +: B] of the assembly register.
  - The word is written when beat BEATS-1 is accepted, or when LoadLast is accepted on any beat.
  - On a partial last word, the unfilled beats are written as zero.
- Address: the write address is WordCount[A-1:0].
  - WordCount increments per word written and saturates at DEPTH.
  - Once WordCount == DEPTH, further words are dropped and LoadErr is set.
  - Beats are still consumed until LoadLast.
- LoadLast with zero beats is impossible, since the LoadLast beat always carries data.
- Fetch:
  - In RUN, FetchEn captures mem[InstAddress] into InstrOut and sets InstrValid for one cycle.
  - Outside RUN, FetchEn is ignored: InstrValid = 0 and InstrOut holds its value.
  - In RUN with FetchEn = 0: InstrValid = 0 and InstrOut holds.
- Simultaneous LoadStart & FetchEn in RUN: LoadStart wins, no fetch, InstrValid = 0 next cycle.
- Memory array is not reset. Fetches of addresses at or above WordCount return stale contents with no flag.

## Timing
- Reset values: InstrOut = 0, InstrValid = 0, LoadReady = 0, Busy = 0, LoadDone = 0, LoadErr = 0, WordCount = 0, beat index = 0.
- Write latency: a word accepted at edge N is readable by a fetch issued in cycle N+1 or later.
- Fetch latency is 1 cycle: address at edge N, InstrOut/InstrValid valid after edge N.
- LoadDone rises at the same edge as the state transition to RUN.
- Busy, LoadDone and LoadErr are registered.
- Reset mid-load:
  - Returns to IDLE and discards the partial assembly word.
  - Already-written words are retained.
  - WordCount, LoadDone and LoadErr are cleared.
- LoadValid held low in LOAD stalls indefinitely with no timeout.

## Structure
- Package prog_mem_pkg holds:
  - State enum (IDLE, LOAD, RUN).
  - Function beats_per_word(W, B).
  - Elaboration-time check that W % B == 0.
- One sub-module, prog_mem_array: DEPTH x W storage with one synchronous write port (we, waddr, wdata) and one registered read port (re, raddr, rdata).
- The loader FSM, packer and fetch gating live in prog_mem.

## Test plan
- Reset then FetchEn = 1, InstAddress = 5 -> InstrValid stays 0, InstrOut = 0, LoadReady = 0.
- LoadStart, then beats 0xA, 0x5, 0x3, 0xC with LoadLast on beat 4 ->
  - mem[0] = 0x5A, mem[1] = 0xC3.
  - WordCount = 2, LoadDone = 1, LoadErr = 0.
  - Fetch addr 1 -> InstrOut = 0xC3, InstrValid = 1 one cycle later.
- Odd beat count: beats 0x1, 0x2, 0x7 with LoadLast on 0x7 -> mem[1] = 0x07, WordCount = 2.
- Overflow: 130 beats (65 words), LoadLast on beat 130 ->
  - WordCount = 64, LoadErr = 1.
  - mem[0] keeps word 0, not word 64.
  - LoadDone = 1.
- Back-pressure and restart:
  - LoadValid toggling 1/0 each cycle still packs correctly.
  - LoadStart in RUN with simultaneous FetchEn -> no InstrValid, Busy = 1, WordCount = 0.
- Reset after 3 beats of a reload -> IDLE, mem[0] holds the new word, mem[1] unchanged, LoadDone = 0.
